// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM generator and capture blocks.
//   WIDTH          : bit width of counters and compare/measurement values.
//   CLK_HZ         : nominal system clock frequency.
//   SERVO_PERIOD   : nominal servo frame length in clk cycles (20 ms at CLK_HZ).
//   MIN_PULSE      : shortest legal servo pulse in clk cycles (0.5 ms).
//   MAX_PULSE      : longest legal servo pulse in clk cycles (2.5 ms).
//   TIMEOUT        : default loss-of-signal limit, the largest count WIDTH bits can hold.
//   state_e        : capture FSM states.
package servo_pkg;

  localparam int unsigned WIDTH        = 20;
  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned SERVO_PERIOD = CLK_HZ / 50;
  localparam int unsigned MIN_PULSE    = CLK_HZ / 2_000;
  localparam int unsigned MAX_PULSE    = CLK_HZ / 400;
  localparam int unsigned TIMEOUT      = (1 << WIDTH) - 1;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Input synchroniser with edge detection, reusable by any input-capture block.
//   clk      : system clock.
//   rst      : synchronous, active-high reset.
//   async_in : asynchronous input level.
//   s        : synchronised level (last of SYNC_STAGES flops).
//   rise     : one-cycle strobe, s went 0 -> 1.
//   fall     : one-cycle strobe, s went 1 -> 0.
module sync_edge_detect import servo_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic s,
  output logic rise,
  output logic fall
);

  // The chain is cleared by reset, so its contents are not real samples until it
  // has refilled. Edges are suppressed until both s and s_d hold genuine samples;
  // otherwise an input that is high across reset would look like a fresh rise.
  localparam int unsigned FillMax = SYNC_STAGES + 1;
  localparam int unsigned FillW   = $clog2(FillMax + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [FillW-1:0]       fill_q;
  logic                   primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
      if (fill_q != FillW'(FillMax)) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  assign primed = (fill_q == FillW'(FillMax));
  assign s      = sync_q[SYNC_STAGES-1];
  assign rise   = primed & s & ~s_d_q;
  assign fall   = primed & ~s & s_d_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures high width and rise-to-rise period of an
// asynchronous servo-style PWM input, in clk cycles.
//   clk         : system clock.
//   rst         : synchronous, active-high reset.
//   pwm_in      : asynchronous PWM input.
//   pulse_width : last measured high time.
//   period      : last measured rise-to-rise period.
//   valid       : one-cycle strobe, pulse_width/period updated this cycle.
//   range_err   : published pulse_width lies outside [MIN_PULSE, MAX_PULSE].
//   signal_lost : no valid PWM since reset or since the last timeout.
module servo_pwm_capture import servo_pkg::*; #(
  parameter int unsigned WIDTH       = servo_pkg::WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_PULSE   = servo_pkg::MIN_PULSE,
  parameter int unsigned MAX_PULSE   = servo_pkg::MAX_PULSE,
  parameter int unsigned TIMEOUT     = servo_pkg::TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] pulse_width,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             range_err,
  output logic             signal_lost
);

  localparam logic [1:0] StAcquire = ACQUIRE;
  localparam logic [1:0] StHigh    = HIGH;
  localparam logic [1:0] StLow     = LOW;

  logic s;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (pwm_in),
    .s        (s),
    .rise     (rise),
    .fall     (fall)
  );

  logic [1:0]       state_q,       state_d;
  logic [WIDTH-1:0] hi_cnt_q,      hi_cnt_d;
  logic [WIDTH-1:0] per_cnt_q,     per_cnt_d;
  logic [WIDTH-1:0] hi_lat_q,      hi_lat_d;
  logic [WIDTH-1:0] pulse_width_q, pulse_width_d;
  logic [WIDTH-1:0] period_q,      period_d;
  logic             valid_q,       valid_d;
  logic             range_err_q,   range_err_d;
  logic             signal_lost_q, signal_lost_d;
  logic             timeout;

  // per_cnt is never allowed past TIMEOUT, so the counters cannot wrap.
  assign timeout = (per_cnt_q >= WIDTH'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    hi_cnt_d      = hi_cnt_q;
    per_cnt_d     = per_cnt_q;
    hi_lat_d      = hi_lat_q;
    pulse_width_d = pulse_width_q;
    period_d      = period_q;
    valid_d       = 1'b0;
    range_err_d   = range_err_q;
    signal_lost_d = signal_lost_q;

    unique case (state_q)
      StAcquire: begin
        // Level is ignored here; only a clean rise starts a measurement.
        if (rise) begin
          state_d   = StHigh;
          hi_cnt_d  = WIDTH'(1);
          per_cnt_d = WIDTH'(1);
        end
      end

      StHigh: begin
        if (timeout) begin
          state_d       = StAcquire;
          signal_lost_d = 1'b1;
        end else if (fall) begin
          state_d   = StLow;
          hi_lat_d  = hi_cnt_q;
          per_cnt_d = per_cnt_q + 1'b1;
        end else if (s) begin
          hi_cnt_d  = hi_cnt_q + 1'b1;
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end

      StLow: begin
        // A rise in the same cycle as the timeout still publishes.
        if (rise) begin
          pulse_width_d = hi_lat_q;
          period_d      = per_cnt_q;
          valid_d       = 1'b1;
          range_err_d   = (hi_lat_q < WIDTH'(MIN_PULSE)) | (hi_lat_q > WIDTH'(MAX_PULSE));
          signal_lost_d = 1'b0;
          state_d       = StHigh;
          hi_cnt_d      = WIDTH'(1);
          per_cnt_d     = WIDTH'(1);
        end else if (timeout) begin
          state_d       = StAcquire;
          signal_lost_d = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StAcquire;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StAcquire;
      hi_cnt_q      <= '0;
      per_cnt_q     <= '0;
      hi_lat_q      <= '0;
      pulse_width_q <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      range_err_q   <= 1'b0;
      signal_lost_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      hi_cnt_q      <= hi_cnt_d;
      per_cnt_q     <= per_cnt_d;
      hi_lat_q      <= hi_lat_d;
      pulse_width_q <= pulse_width_d;
      period_q      <= period_d;
      valid_q       <= valid_d;
      range_err_q   <= range_err_d;
      signal_lost_q <= signal_lost_d;
    end
  end

  assign pulse_width = pulse_width_q;
  assign period      = period_q;
  assign valid       = valid_q;
  assign range_err   = range_err_q;
  assign signal_lost = signal_lost_q;

endmodule
